float_expand_stream: RTL and testbench



---
 rtl/float_expand_stream_pkg.sv | 20 ++
 rtl/float_expand_stream_denormal_normalizer.sv | 69 ++++++
 rtl/float_expand_stream.sv | 134 +++++++++++++
 tb/tb_float_expand_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_expand_stream_pkg.sv
// Shared types and elaboration helpers for the narrow-to-wide float expander.
package float_expand_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } expand_state_e;

  function automatic int get_exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Shift step clamped to 1..frac_in so a bad parameter cannot stall or over-shift.
  function automatic int get_expand_shift_limit(input int shift_step, input int frac_in);
    if (shift_step < 1) return 1;
    if (shift_step > frac_in) return frac_in;
    return shift_step;
  endfunction

endpackage

// File: rtl/float_expand_stream_denormal_normalizer.sv
// Serial normalizer: left-justifies a narrow denormal mantissa by at most
// SHIFT_STEP bits per step while tracking the widened exponent.
module float_denormal_normalizer
  import float_expand_stream_pkg::*;
#(
  parameter int FRAC_IN    = 10,
  parameter int EXP_OUT    = 8,
  parameter int SHIFT_STEP = 4,
  parameter int DIFF       = 112
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAC_IN-1:0] frac,
  input  logic               step,
  output logic               done,
  output logic [FRAC_IN-1:0] mantissa,
  output logic [EXP_OUT-1:0] exponent
);

  localparam int LIMIT = get_expand_shift_limit(SHIFT_STEP, FRAC_IN);
  localparam int CW    = $clog2(FRAC_IN + 2);

  typedef logic [CW-1:0]    cnt_t;
  typedef logic [FRAC_IN:0] mant_t;
  typedef logic [EXP_OUT:0] acc_t;

  mant_t m_q, m_shift;
  acc_t  acc_q, acc_shift;
  cnt_t  lz, k;
  logic  found;
  logic  acc_msb_unused;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = FRAC_IN; i >= 0; i--) begin
      if (!found) begin
        if (m_q[i]) found = 1'b1;
        else        lz    = lz + cnt_t'(1);
      end
    end
    k         = (lz < cnt_t'(LIMIT)) ? lz : cnt_t'(LIMIT);
    m_shift   = m_q << k;
    acc_shift = acc_q - acc_t'(k);
  end

  // Outputs preview the post-step value so the top can retire in the same cycle.
  assign done           = m_shift[FRAC_IN];
  assign mantissa       = m_shift[FRAC_IN-1:0];
  assign exponent       = acc_shift[EXP_OUT-1:0];
  assign acc_msb_unused = acc_shift[EXP_OUT];

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      m_q   <= {1'b0, frac};
      acc_q <= acc_t'(DIFF + 1);
    end else if (step) begin
      m_q   <= m_shift;
      acc_q <= acc_shift;
    end
  end

endmodule

// File: rtl/float_expand_stream.sv
// Streaming exact widening float converter with valid/ready on both sides;
// denormal inputs are normalized serially, everything else in one cycle.
module float_expand_stream
  import float_expand_stream_pkg::*;
#(
  parameter int EXP_IN     = 5,
  parameter int FRAC_IN    = 10,
  parameter int EXP_OUT    = 8,
  parameter int FRAC_OUT   = 23,
  parameter int SHIFT_STEP = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [EXP_IN+FRAC_IN:0]     in,
  input  logic                        inValid,
  output logic                        inReady,
  output logic [EXP_OUT+FRAC_OUT:0]   out,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        isNanOut
);

  localparam int DIFF = get_exp_bias(EXP_OUT) - get_exp_bias(EXP_IN);

  if (EXP_OUT <= EXP_IN) begin : g_bad_exp
    $error("EXP_OUT must be wider than EXP_IN");
  end
  if (FRAC_OUT < FRAC_IN) begin : g_bad_frac
    $error("FRAC_OUT must be at least FRAC_IN");
  end
  if (DIFF < FRAC_IN) begin : g_bad_diff
    $error("bias difference too small to normalize every input denormal");
  end

  typedef logic [EXP_OUT-1:0]  exp_out_t;
  typedef logic [FRAC_OUT-1:0] frac_out_t;

  expand_state_e             state_q;
  logic [EXP_OUT+FRAC_OUT:0] out_q;
  logic                      out_valid_q, nan_q, sign_q;

  logic               sign_in, exp_max, exp_zero, frac_zero, is_denorm;
  logic [EXP_IN-1:0]  exp_in;
  logic [FRAC_IN-1:0] frac_in;
  logic               out_free, accept, norm_step, norm_done;
  exp_out_t           res_exp, norm_exp;
  frac_out_t          res_frac;
  logic               res_nan;
  logic [FRAC_IN-1:0] norm_mant;

  assign {sign_in, exp_in, frac_in} = in;
  assign exp_max   = &exp_in;
  assign exp_zero  = ~|exp_in;
  assign frac_zero = ~|frac_in;
  assign is_denorm = exp_zero && !frac_zero;

  assign out_free  = !out_valid_q || outReady;
  assign inReady   = (state_q == IDLE) && out_free;
  assign accept    = inValid && inReady;
  assign norm_step = (state_q == NORM) && (!norm_done || out_free);

  always_comb begin
    res_exp  = '0;
    res_frac = '0;
    res_nan  = 1'b0;
    if (exp_max) begin
      res_exp = '1;
      if (!frac_zero) begin
        res_frac = frac_out_t'(1) << (FRAC_OUT - 1);
        res_nan  = 1'b1;
      end
    end else if (!exp_zero) begin
      res_exp  = exp_out_t'(exp_in) + exp_out_t'(DIFF);
      res_frac = frac_out_t'(frac_in) << (FRAC_OUT - FRAC_IN);
    end
  end

  float_denormal_normalizer #(
    .FRAC_IN   (FRAC_IN),
    .EXP_OUT   (EXP_OUT),
    .SHIFT_STEP(SHIFT_STEP),
    .DIFF      (DIFF)
  ) u_norm (
    .clock   (clock),
    .reset   (reset),
    .load    (accept && is_denorm),
    .frac    (frac_in),
    .step    (norm_step),
    .done    (norm_done),
    .mantissa(norm_mant),
    .exponent(norm_exp)
  );

  // A new result written in the same cycle as a drain overrides the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      nan_q       <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      if (out_valid_q && outReady) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_denorm) begin
              state_q <= NORM;
              sign_q  <= sign_in;
            end else begin
              out_q       <= {sign_in, res_exp, res_frac};
              nan_q       <= res_nan;
              out_valid_q <= 1'b1;
            end
          end
        end
        NORM: begin
          if (norm_done && out_free) begin
            out_q       <= {sign_q, norm_exp, frac_out_t'(norm_mant) << (FRAC_OUT - FRAC_IN)};
            nan_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign outValid = out_valid_q;
  assign isNanOut = nan_q;

endmodule

// File: tb/tb_float_expand_stream.sv
// Self-checking bench: value-level half->single model with a FIFO scoreboard,
// directed corner cases and a randomized handshake phase.
module tb_float_expand_stream;

  logic        clock, reset;
  logic [15:0] din;
  logic        inValid, inReady;
  logic [31:0] dout;
  logic        outValid, outReady, isNanOut;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int stalls   = 0;

  logic [32:0] exp_q[$];
  logic        held_prev = 1'b0;
  logic [32:0] prev_out  = '0;

  float_expand_stream dut (
    .clock   (clock),
    .reset   (reset),
    .in      (din),
    .inValid (inValid),
    .inReady (inReady),
    .out     (dout),
    .outValid(outValid),
    .outReady(outReady),
    .isNanOut(isNanOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference by value: {isNan, single-precision bits}.
  function automatic logic [32:0] model(input logic [15:0] h);
    logic s;
    int   e, f, p, eo, fo;
    s = h[15];
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    p = 0;
    if (e == 31) return (f == 0) ? {1'b0, s, 8'hFF, 23'h0} : {1'b1, s, 8'hFF, 23'h400000};
    if (e == 0 && f == 0) return {1'b0, s, 31'h0};
    if (e == 0) begin
      for (int b = 0; b < 10; b++) if (((f >> b) & 1) == 1) p = b;
      eo = 127 + p - 24;
      fo = (f << (23 - p)) & 32'h7FFFFF;
    end else begin
      eo = e - 15 + 127;
      fo = f << 13;
    end
    return {1'b0, s, eo[7:0], fo[22:0]};
  endfunction

  function automatic int denorm_latency(input logic [15:0] h);
    int p, s;
    p = 0;
    for (int b = 0; b < 10; b++) if (h[b]) p = b;
    s = 10 - p;
    return 1 + (s + 3) / 4;
  endfunction

  // Scoreboard: every cycle checks inReady, output handshake, hold stability.
  always @(negedge clock) begin
    int pending;
    logic [32:0] e;
    if (reset) begin
      held_prev = 1'b0;
    end else begin
      pending = exp_q.size() - (outValid ? 1 : 0);
      check("inReady", {63'd0, inReady}, {63'd0, (pending == 0) && (!outValid || outReady)});
      if (held_prev) check("hold stable", {30'd0, outValid, isNanOut, dout}, {30'd0, 1'b1, prev_out});
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          check("output with empty model", {63'd0, outValid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {31'd0, isNanOut, dout}, {31'd0, e});
        end
      end
      held_prev = outValid && !outReady;
      prev_out  = {isNanOut, dout};
      if (inValid && inReady) exp_q.push_back(model(din));
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [15:0] h);
    bit ok;
    ok      = 1'b0;
    din     = h;
    inValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (inReady) begin
        acc_cyc = cyc;
        ok      = 1'b1;
        break;
      end
      stalls++;
    end
    check("send accepted", {63'd0, ok}, 64'd1);
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int lat, input bit in_norm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (outValid) begin
        got = 1'b1;
        break;
      end
      if (in_norm) check({name, " inReady low in NORM"}, {63'd0, inReady}, 64'd0);
    end
    check({name, " seen"}, {63'd0, got}, 64'd1);
    if (got) check({name, " latency"}, 64'(cyc - acc_cyc), 64'(lat));
    @(posedge clock);
    #1;
  endtask

  task automatic random_half(output logic [15:0] h);
    logic [9:0] f;
    f = 10'($urandom);
    case ($urandom % 6)
      0:       h = {1'($urandom), 5'd0, f};
      1:       h = {1'($urandom), 5'h1F, ($urandom % 2 == 0) ? 10'd0 : f};
      2:       h = {1'($urandom), 15'd0};
      default: h = 16'($urandom);
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h;
    bit fire;
    reset = 1'b1; inValid = 1'b0; din = '0; outReady = 1'b1;

    check("model 3C00", 64'(model(16'h3C00)), 64'h0_3F80_0000);
    check("model 7BFF", 64'(model(16'h7BFF)), 64'h0_477F_E000);
    check("model FC00", 64'(model(16'hFC00)), 64'h0_FF80_0000);
    check("model 7E01", 64'(model(16'h7E01)), 64'h1_7FC0_0000);
    check("model 0001", 64'(model(16'h0001)), 64'h0_3380_0000);
    check("model 0200", 64'(model(16'h0200)), 64'h0_3800_0000);
    check("model 8001", 64'(model(16'h8001)), 64'h0_B380_0000);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset outValid", {63'd0, outValid}, 64'd0);
    check("reset out", {32'd0, dout}, 64'd0);
    check("reset isNanOut", {63'd0, isNanOut}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle inReady", {63'd0, inReady}, 64'd1);

    stalls = 0;
    send(16'h3C00); send(16'h7BFF); send(16'hFC00);
    check("back-to-back stalls", 64'(stalls), 64'd0);
    repeat (3) @(posedge clock); #1;

    send(16'h7E01); wait_out("nan", 1, 1'b0);
    send(16'h0000); wait_out("zero", 1, 1'b0);
    send(16'h8000); wait_out("neg zero", 1, 1'b0);

    send(16'h0001); wait_out("denorm 0001", denorm_latency(16'h0001), 1'b1);
    check("denorm 0001 latency model", 64'(denorm_latency(16'h0001)), 64'd4);
    send(16'h0200); wait_out("denorm 0200", denorm_latency(16'h0200), 1'b1);
    send(16'h8001); wait_out("denorm 8001", denorm_latency(16'h8001), 1'b1);

    // Backpressure: result must hold while the next operand waits.
    din = 16'h3C00; inValid = 1'b1;
    @(negedge clock);
    check("bp first ready", {63'd0, inReady}, 64'd1);
    @(posedge clock); #1;
    din = 16'h7BFF; outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp out held", {32'd0, dout}, 64'h3F80_0000);
      check("bp outValid", {63'd0, outValid}, 64'd1);
      check("bp inReady low", {63'd0, inReady}, 64'd0);
      @(posedge clock); #1;
    end
    outReady = 1'b1;
    @(negedge clock);
    check("bp release accept", {63'd0, inReady}, 64'd1);
    @(posedge clock); #1;
    inValid = 1'b0;
    repeat (3) @(posedge clock); #1;

    // Reset while a denormal is normalizing: nothing may come out.
    send(16'h0001);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid-NORM reset outValid", {63'd0, outValid}, 64'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("no stale result", {63'd0, outValid}, 64'd0);
    end
    @(posedge clock); #1;
    send(16'h3C00); wait_out("post-reset 3C00", 1, 1'b0);

    // Randomized traffic with random backpressure.
    inValid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      fire = inValid && inReady;
      @(posedge clock); #1;
      if (!inValid || fire) begin
        random_half(h);
        din     = h;
        inValid = ($urandom % 4) != 0;
      end
      outReady = ($urandom % 3) != 0;
    end
    @(negedge clock);
    fire = inValid && inReady;
    @(posedge clock); #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    check("drain empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
